// File: rtl/axil_kg_regfile.sv
// axil_kg_regfile: AXI4-Lite slave register file for the Kugelblitz offload
// control values of one port. Four RW registers (ADDR, ADDR_VALID, DATA,
// DATA_VALID) drive the flat kg_* buses directly from flops.
//
// Optional build macro: AXIL_KG_REGFILE_ID_EN
//   defined   -> offset 0x10 reads the constant 32'h4B47_0001
//   undefined -> offset 0x10 is unmapped and reads 0
// Writes to 0x10 are always ignored. Every access responds OKAY.
module axil_kg_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [DATA_WIDTH-1:0] kg_address,
    output logic [DATA_WIDTH-1:0] kg_address_valid,
    output logic [DATA_WIDTH-1:0] kg_data,
    output logic [DATA_WIDTH-1:0] kg_data_valid
);

    // Word offsets within the 256-byte aliased window.
    localparam logic [5:0] OFF_ADDR       = 6'h00;
    localparam logic [5:0] OFF_ADDR_VALID = 6'h01;
    localparam logic [5:0] OFF_DATA       = 6'h02;
    localparam logic [5:0] OFF_DATA_VALID = 6'h03;
`ifdef AXIL_KG_REGFILE_ID_EN
    localparam logic [5:0] OFF_ID         = 6'h04;
    localparam logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(32'h4B47_0001);
`endif

    localparam int NUM_REGS = 4;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [5:0]            wr_off;
    logic [5:0]            rd_off;
    logic                  wr_fire;
    logic                  rd_fire;

    assign wr_off = s_axil_awaddr[7:2];
    assign rd_off = s_axil_araddr[7:2];

    // A write is taken only with address and data together and no response
    // outstanding; both readies pulse in that same cycle. Reset masks the
    // readies so nothing is acknowledged while the block is being cleared.
    assign wr_fire = s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~rst;
    assign rd_fire = s_axil_arvalid & ~rvalid_q & ~rst;

    assign s_axil_awready = wr_fire;
    assign s_axil_wready  = wr_fire;
    assign s_axil_arready = rd_fire;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rresp   = 2'b00;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;

    assign kg_address       = regs_q[0];
    assign kg_address_valid = regs_q[1];
    assign kg_data          = regs_q[2];
    assign kg_data_valid    = regs_q[3];

    // Next register values: byte-lane merge of the accepted write data.
    always_comb begin
        // NOTE: every output of an always_comb gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_fire && (wr_off < 6'(NUM_REGS))) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_off == 6'(i)) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (s_axil_wstrb[b]) begin
                            regs_d[i][8*b +: 8] = s_axil_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read decode from the current (pre-write) register contents.
    always_comb begin
        rd_word = '0;
        case (rd_off)
            OFF_ADDR:       rd_word = regs_q[0];
            OFF_ADDR_VALID: rd_word = regs_q[1];
            OFF_DATA:       rd_word = regs_q[2];
            OFF_DATA_VALID: rd_word = regs_q[3];
`ifdef AXIL_KG_REGFILE_ID_EN
            OFF_ID:         rd_word = ID_VALUE;
`endif
            default:        rd_word = '0;
        endcase
    end

    // Register state plus write-response and read-data handshakes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before this edge regardless of order.
        if (rst) begin
            // NOTE: this small array is plain flops, not a RAM macro, so it
            // can and must be cleared by reset like any other register.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end

            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_axil_bready) begin
                bvalid_q <= 1'b0;
            end

            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (rvalid_q && s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Address bits outside the word offset and the prot fields carry no
    // meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot,
                             s_axil_awaddr[ADDR_WIDTH-1:8], s_axil_awaddr[1:0],
                             s_axil_araddr[ADDR_WIDTH-1:8], s_axil_araddr[1:0]};

endmodule

// File: tb/tb_axil_kg_regfile.sv
// tb_axil_kg_regfile: directed self-checking bench for axil_kg_regfile.
// Honours AXIL_KG_REGFILE_ID_EN when choosing the expected ID readback.
module tb_axil_kg_regfile;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TIMEOUT = 20;

`ifdef AXIL_KG_REGFILE_ID_EN
    localparam logic [31:0] EXP_ID = 32'h4B47_0001;
`else
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_axil_awaddr;
    logic [2:0]    s_axil_awprot;
    logic          s_axil_awvalid;
    logic          s_axil_awready;
    logic [DW-1:0] s_axil_wdata;
    logic [SW-1:0] s_axil_wstrb;
    logic          s_axil_wvalid;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;
    logic [DW-1:0] kg_address;
    logic [DW-1:0] kg_address_valid;
    logic [DW-1:0] kg_data;
    logic [DW-1:0] kg_data_valid;

    always #5 clk = ~clk;

    axil_kg_regfile #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axil_awaddr   (s_axil_awaddr),
        .s_axil_awprot   (s_axil_awprot),
        .s_axil_awvalid  (s_axil_awvalid),
        .s_axil_awready  (s_axil_awready),
        .s_axil_wdata    (s_axil_wdata),
        .s_axil_wstrb    (s_axil_wstrb),
        .s_axil_wvalid   (s_axil_wvalid),
        .s_axil_wready   (s_axil_wready),
        .s_axil_bresp    (s_axil_bresp),
        .s_axil_bvalid   (s_axil_bvalid),
        .s_axil_bready   (s_axil_bready),
        .s_axil_araddr   (s_axil_araddr),
        .s_axil_arprot   (s_axil_arprot),
        .s_axil_arvalid  (s_axil_arvalid),
        .s_axil_arready  (s_axil_arready),
        .s_axil_rdata    (s_axil_rdata),
        .s_axil_rresp    (s_axil_rresp),
        .s_axil_rvalid   (s_axil_rvalid),
        .s_axil_rready   (s_axil_rready),
        .kg_address      (kg_address),
        .kg_address_valid(kg_address_valid),
        .kg_data         (kg_data),
        .kg_data_valid   (kg_data_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Tasks start just after a rising edge; outputs are sampled on the
    // falling edge or 1 time unit after a rising edge.
    task automatic wr_issue(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        s_axil_awaddr  = addr;
        s_axil_wdata   = data;
        s_axil_wstrb   = strb;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        @(negedge clk);
        while (!(s_axil_awready && s_axil_wready) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wr_accept"}, 32'(s_axil_awready && s_axil_wready), 32'd1);
        @(posedge clk);
        #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check({tag, "_bvalid"}, 32'(s_axil_bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(s_axil_bresp), 32'd0);
    endtask

    task automatic wr_resp(input string tag);
        s_axil_bready = 1'b1;
        @(posedge clk);
        #1;
        s_axil_bready = 1'b0;
        check({tag, "_bvalid_clr"}, 32'(s_axil_bvalid), 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, output logic [31:0] data);
        int n = 0;
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        @(negedge clk);
        while (!s_axil_arready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_arready"}, 32'(s_axil_arready), 32'd1);
        @(posedge clk);
        #1;
        s_axil_arvalid = 1'b0;
        check({tag, "_rvalid"}, 32'(s_axil_rvalid), 32'd1);
        check({tag, "_rresp"}, 32'(s_axil_rresp), 32'd0);
        data = s_axil_rdata;
        s_axil_rready = 1'b1;
        @(posedge clk);
        #1;
        s_axil_rready = 1'b0;
        check({tag, "_rvalid_clr"}, 32'(s_axil_rvalid), 32'd0);
    endtask

    logic [31:0] rv;

    initial begin
        rst            = 1'b1;
        s_axil_awaddr  = '0;
        s_axil_awprot  = '0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = '0;
        s_axil_wstrb   = '0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        s_axil_araddr  = '0;
        s_axil_arprot  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
        check("rst_rdata", s_axil_rdata, 32'd0);
        check("rst_kg_address", kg_address, 32'd0);
        check("rst_kg_address_valid", kg_address_valid, 32'd0);
        check("rst_kg_data", kg_data, 32'd0);
        check("rst_kg_data_valid", kg_data_valid, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        rd("rst_rd00", 32'h00, rv); check("rst_rd00_data", rv, 32'd0);
        rd("rst_rd04", 32'h04, rv); check("rst_rd04_data", rv, 32'd0);
        rd("rst_rd08", 32'h08, rv); check("rst_rd08_data", rv, 32'd0);
        rd("rst_rd0c", 32'h0C, rv); check("rst_rd0c_data", rv, 32'd0);

        // Full-word write: kg_address visible as bvalid rises.
        wr_issue("wr_addr", 32'h00, 32'h0000_000E, 4'hF);
        check("wr_addr_kg", kg_address, 32'h0000_000E);
        wr_resp("wr_addr");
        rd("rb_addr", 32'h00, rv); check("rb_addr_data", rv, 32'h0000_000E);

        // Partial strobe write merges only byte lane 1.
        wr_issue("wr_data_full", 32'h08, 32'h1122_3344, 4'hF);
        wr_resp("wr_data_full");
        wr_issue("wr_data_strb", 32'h08, 32'hAABB_CCDD, 4'h2);
        check("wr_data_strb_kg", kg_data, 32'h1122_CC44);
        wr_resp("wr_data_strb");
        rd("rb_data", 32'h08, rv); check("rb_data_data", rv, 32'h1122_CC44);

        // Address arrives three cycles ahead of data.
        s_axil_awaddr  = 32'h04;
        s_axil_wdata   = 32'h0000_0001;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_early_awready", 32'(s_axil_awready), 32'd0);
            check("aw_early_wready", 32'(s_axil_wready), 32'd0);
            check("aw_early_bvalid", 32'(s_axil_bvalid), 32'd0);
            @(posedge clk);
            #1;
        end
        s_axil_wvalid = 1'b1;
        @(negedge clk);
        check("aw_early_accept", 32'(s_axil_awready && s_axil_wready), 32'd1);
        @(posedge clk);
        #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check("aw_early_bvalid_up", 32'(s_axil_bvalid), 32'd1);
        check("aw_early_kg", kg_address_valid, 32'd1);

        // bready held low: response stays, a second write is refused.
        s_axil_awaddr  = 32'h0C;
        s_axil_wdata   = 32'h0000_0055;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bhold_awready", 32'(s_axil_awready), 32'd0);
            check("bhold_wready", 32'(s_axil_wready), 32'd0);
            check("bhold_bvalid", 32'(s_axil_bvalid), 32'd1);
            @(posedge clk);
            #1;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check("bhold_kg_dv", kg_data_valid, 32'd0);
        wr_resp("bhold");
        @(posedge clk);
        #1;
        check("bhold_single_resp", 32'(s_axil_bvalid), 32'd0);

        // Unmapped offset, alias, and the ID slot (writes ignored).
        wr_issue("wr_unmapped", 32'h20, 32'hDEAD_BEEF, 4'hF);
        wr_resp("wr_unmapped");
        rd("rd_unmapped", 32'h20, rv); check("rd_unmapped_data", rv, 32'd0);
        rd("rd_alias", 32'h104, rv); check("rd_alias_data", rv, 32'd1);
        wr_issue("wr_id", 32'h10, 32'hFFFF_FFFF, 4'hF);
        wr_resp("wr_id");
        rd("rd_id", 32'h10, rv); check("rd_id_data", rv, EXP_ID);
        check("unmapped_kg_address", kg_address, 32'h0000_000E);
        check("unmapped_kg_data", kg_data, 32'h1122_CC44);
        check("unmapped_kg_dv", kg_data_valid, 32'd0);

        // Read and write of ADDR on the same edge: read sees the old value.
        s_axil_awaddr  = 32'h00;
        s_axil_wdata   = 32'h0000_005A;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        s_axil_araddr  = 32'h00;
        s_axil_arvalid = 1'b1;
        @(negedge clk);
        check("sim_awready", 32'(s_axil_awready), 32'd1);
        check("sim_arready", 32'(s_axil_arready), 32'd1);
        @(posedge clk);
        #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_arvalid = 1'b0;
        check("sim_rdata_old", s_axil_rdata, 32'h0000_000E);
        check("sim_kg_new", kg_address, 32'h0000_005A);
        s_axil_bready = 1'b1;
        s_axil_rready = 1'b1;
        @(posedge clk);
        #1;
        s_axil_bready = 1'b0;
        s_axil_rready = 1'b0;
        check("sim_bvalid_clr", 32'(s_axil_bvalid), 32'd0);
        check("sim_rvalid_clr", 32'(s_axil_rvalid), 32'd0);

        // Reset with both a write response and read data pending.
        wr_issue("wr_pre_rst", 32'h0C, 32'h0000_0077, 4'hF);
        check("pre_rst_kg_dv", kg_data_valid, 32'h0000_0077);
        s_axil_araddr  = 32'h08;
        s_axil_arvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axil_arvalid = 1'b0;
        check("pre_rst_rvalid", 32'(s_axil_rvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_bvalid", 32'(s_axil_bvalid), 32'd0);
        check("mid_rst_rvalid", 32'(s_axil_rvalid), 32'd0);
        check("mid_rst_kg_address", kg_address, 32'd0);
        check("mid_rst_kg_address_valid", kg_address_valid, 32'd0);
        check("mid_rst_kg_data", kg_data, 32'd0);
        check("mid_rst_kg_data_valid", kg_data_valid, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd("post_rst_rd08", 32'h08, rv); check("post_rst_rd08_data", rv, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_kg_regfile.md
Name: axil_kg_regfile

Overview:
- AXI4-Lite slave register file holding the Kugelblitz offload control values: byte-lane address, address-valid, data and data-valid.
- One instance per port inside the Kugelblitz offload wrapper.
- Register contents drive flat output buses continuously; the datapath uses them to overwrite or insert bytes in passing Ethernet frames.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width in bits; must be 32.
- ADDR_WIDTH, 32, AXI-Lite address width in bits; must be at least 8.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width; must equal DATA_WIDTH/8.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address ready.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte write enables.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data ready.
- s_axil_bresp  out  2  always 2'b00 (OKAY).
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address ready.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  always 2'b00 (OKAY).
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.
- kg_address  out  DATA_WIDTH  ADDR register contents.
- kg_address_valid  out  DATA_WIDTH  ADDR_VALID register contents; bit 0 is the enable.
- kg_data  out  DATA_WIDTH  DATA register contents; bits [7:0] are the inserted byte.
- kg_data_valid  out  DATA_WIDTH  DATA_VALID register contents.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Register map, decoded on word offset awaddr/araddr[7:2]; bits [1:0] and bits above [7] are ignored, so the map aliases every 256 bytes:
  - 0x00 ADDR (RW)
  - 0x04 ADDR_VALID (RW)
  - 0x08 DATA (RW)
  - 0x0C DATA_VALID (RW)
  - 0x10 ID (RO; see Optional Feature)
  - all other offsets: reads return 0, writes are ignored; both respond OKAY.
- Reset values: all four registers, awready, wready, bvalid, arready, rvalid and rdata are 0.
- Write channel:
  - Accepted in a cycle where awvalid and wvalid are both 1 and bvalid is 0.
  - On acceptance, awready and wready pulse high together for exactly that one cycle; they are never high alone.
  - The register update lands at the next clock edge, byte lanes enabled per wstrb; lanes with a clear strobe are unchanged.
  - bvalid rises on that same edge, so the kg_* outputs reflect the new value in the same cycle bvalid is first high.
  - bvalid holds until bready; no new write is accepted while bvalid is 1.
  - Writes to the ID offset are ignored.
- Read channel:
  - Accepted in a cycle where arvalid is 1 and rvalid is 0; arready pulses high for that one cycle.
  - rdata and rvalid are registered on the next edge; read latency is 1 cycle.
  - rdata stays stable while rvalid is 1; rvalid clears on rready.
  - Back-to-back reads give at most one transaction per 2 cycles with rready held high.
- Simultaneous read and write:
  - The read and write channels are independent.
  - A read of a register written on the same edge returns the pre-write value.
- kg_* outputs are direct register outputs with no combinational path from AXI inputs.
- Reset asserted mid-transaction aborts any pending response (bvalid and rvalid go to 0) and clears all registers on that edge.

Optional Feature:
- Macro: AXIL_KG_REGFILE_ID_EN.
- When defined: offset 0x10 reads the constant 32'h4B47_0001.
- When not defined: offset 0x10 behaves as unmapped and reads 0.
- In both cases writes to 0x10 have no effect and respond OKAY.

Test Plan:
- Reset then read 0x00, 0x04, 0x08, 0x0C -> each returns 0 with rresp 00; all kg_* outputs are 0.
- Write 0x00 = 0x0000000E, wstrb 0xF -> bresp 00; kg_address = 0xE on the cycle bvalid rises; readback returns 0xE.
- Write 0x08 = 0x11223344, then write 0x08 = 0xAABBCCDD with wstrb 0x2 -> kg_data = 0x1122CC44.
- Present awvalid 3 cycles before wvalid -> no ready and no bvalid until wvalid is high; then one response only. Hold bready = 0 for 4 cycles -> bvalid stays high and a second write is not accepted.
- Read 0x20 and 0x104 -> 0x20 returns 0 with OKAY; 0x104 aliases 0x04 and returns the ADDR_VALID value. Read 0x10 -> 0x4B470001 with AXIL_KG_REGFILE_ID_EN defined, else 0.
- Assert rst while bvalid is pending -> next cycle bvalid = 0 and every kg_* output = 0.
